wb_stage_reg: RTL and testbench
===============================

// Module: wb_stage_reg
// PURPOSE
//  Elastic MEM->WB pipeline register: successor to the fixed 104-bit WB latch.
//  2-entry skid buffer with valid/ready handshake, synchronous flush, x0-write suppression,
//  and a built-in writeback-data mux. Sits between the memory stage and the register file.
//  Exports an occupancy count and forwarding qualifiers for the hazard unit.
// PARAMETERS
//  DATA_WIDTH  32  width of ALU result, load data and writeback data
//  ADDR_WIDTH  32  width of pcn (next-PC / link value)
//  RD_WIDTH    5   destination register index width
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           asynchronous reset, active-low
//  in_valid     in   1           MEM stage presents a beat
//  in_ready     out  1           WB register can accept a beat (registered, no comb path from out_ready)
//  flush        in   1           synchronous flush, discards all held beats
//  reg_wem      in   1           reg-file write enable of incoming beat
//  rdm          in   RD_WIDTH    destination register
//  pcnm         in   ADDR_WIDTH  next PC (link value)
//  alu_resultm  in   DATA_WIDTH  ALU result
//  wb_ctrm      in   2           writeback source select
//  data_out     in   DATA_WIDTH  load data from data memory
//  out_valid    out  1           head entry valid
//  out_ready    in   1           register file / downstream accepts head
//  reg_wew      out  1           qualified write enable (see BEHAVIOUR)
//  rdw          out  RD_WIDTH    head destination register
//  pcnw         out  ADDR_WIDTH  head pcn
//  alu_resultw  out  DATA_WIDTH  head ALU result
//  wb_ctrw      out  2           head writeback select
//  data_outw    out  DATA_WIDTH  head load data
//  wb_dataw     out  DATA_WIDTH  selected writeback value
//  occ          out  2           entries held: 0,1,2
// BEHAVIOUR
//  - Reset (rst=0, async): state EMPTY, both entries' payload = 0, out_valid=0, reg_wew=0,
//    occ=0, wb_dataw=0; in_ready reads 1. No transfer occurs while rst=0.
//  - Accept = in_valid & in_ready; Retire = out_valid & out_ready. Latency in->out = 1 clk.
//  - Entries: HEAD (drives outputs) and SKID. States EMPTY(occ0), ONE(occ1), FULL(occ2).
//    EMPTY: accept -> ONE, HEAD<=in.
//    ONE:   accept&!retire -> FULL, SKID<=in; retire&!accept -> EMPTY;
//           accept&retire -> ONE, HEAD<=in; neither -> hold.
//    FULL:  retire -> ONE, HEAD<=SKID; else hold. in_ready=0 in FULL, so no accept.
//  - in_ready = (state != FULL), derived from state register only.
//  - out_valid = (state != EMPTY).
//  - flush=1 (highest priority, over accept/retire): next state EMPTY; a beat accepted in the
//    flush cycle is consumed and discarded; payload registers may keep stale values, but
//    out_valid and reg_wew must be 0 from the next cycle.
//  - reg_wew = out_valid & HEAD.reg_we & (HEAD.rd != 0). Never 1 for x0 or an empty stage.
//  - wb_dataw (combinational from HEAD): wb_ctr 2'b00 -> alu_result; 2'b01 -> data_out;
//    2'b10 -> zero-extended/truncated pcn to DATA_WIDTH; 2'b11 -> 0.
//  - When out_valid=0, rdw/pcnw/alu_resultw/wb_ctrw/data_outw show HEAD contents (don't-care);
//    only reg_wew and out_valid are guaranteed to be 0.
//  - Order preserved: beats retire strictly in accept order; no drop or duplication except flush.
//  - Reset mid-operation: async clear regardless of state; first post-reset accept -> ONE.
// TESTING
//  1 Reset: fill to FULL, drop rst mid-cycle -> immediately out_valid=0, occ=0, reg_wew=0,
//    wb_dataw=0, in_ready=1.
//  2 Streaming: out_ready=1, beats A,B,C (alu 0x1,0x2,0x3) back-to-back -> alu_resultw 0x1,0x2,0x3
//    on consecutive cycles, occ stays 1, no bubbles.
//  3 Back-pressure: out_ready=0, push A,B -> occ=2, in_ready=0; hold C on input 3 cycles; raise
//    out_ready -> A,B,C retire in order, C accepted the cycle after in_ready returns to 1.
//  4 Flush: FULL with in_valid=1 and flush=1 -> next cycle occ=0, out_valid=0, reg_wew=0;
//    none of the three beats ever appear at the output.
//  5 WB mux: alu=0x11, data=0x22, pcn=0x33, wb_ctr 00/01/10/11 -> wb_dataw 0x11/0x22/0x33/0x0.
//  6 x0 guard: reg_we=1, rd=0 -> reg_wew=0; reg_we=1, rd=5 -> reg_wew=1; reg_we=0, rd=5 -> 0.

Source files
------------

// File: rtl/wb_stage_reg.sv
// Elastic MEM->WB register: 2-entry skid buffer, registered in_ready, flush, x0 write guard, WB mux.
// Latency 1 clk in->out; in_ready drops only when both entries are held (from state register only).
module wb_stage_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  reg_wem,
  input  logic [RD_WIDTH-1:0]   rdm,
  input  logic [ADDR_WIDTH-1:0] pcnm,
  input  logic [DATA_WIDTH-1:0] alu_resultm,
  input  logic [1:0]            wb_ctrm,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  reg_wew,
  output logic [RD_WIDTH-1:0]   rdw,
  output logic [ADDR_WIDTH-1:0] pcnw,
  output logic [DATA_WIDTH-1:0] alu_resultw,
  output logic [1:0]            wb_ctrw,
  output logic [DATA_WIDTH-1:0] data_outw,
  output logic [DATA_WIDTH-1:0] wb_dataw,
  output logic [1:0]            occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  reg_we;
    logic [RD_WIDTH-1:0]   rd;
    logic [ADDR_WIDTH-1:0] pcn;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [1:0]            wb_ctr;
    logic [DATA_WIDTH-1:0] data_out;
  } beat_t;

  state_t state, state_nxt;
  beat_t  head, skid, in_beat;
  logic   accept, retire;
  logic   load_head_in, load_head_skid, load_skid;
  logic [DATA_WIDTH-1:0] pcn_ext;

  assign in_beat = '{reg_we: reg_wem, rd: rdm, pcn: pcnm, alu_result: alu_resultm,
                     wb_ctr: wb_ctrm, data_out: data_out};

  assign accept = in_valid & in_ready;
  assign retire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt    = ONE;
            load_head_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && !retire) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (retire && !accept) begin
            state_nxt = EMPTY;
          end else if (accept && retire) begin
            load_head_in = 1'b1;
          end
        end
        FULL: begin
          if (retire) begin
            state_nxt      = ONE;
            load_head_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    occ       = state;
    reg_wew   = out_valid & head.reg_we & (head.rd != '0);
    case (head.wb_ctr)
      2'b00:   wb_dataw = head.alu_result;
      2'b01:   wb_dataw = head.data_out;
      2'b10:   wb_dataw = pcn_ext;
      default: wb_dataw = '0;
    endcase
  end

  // Flush leaves payload untouched; only the state is cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (load_head_in)        head <= in_beat;
      else if (load_head_skid) head <= skid;
      if (load_skid)           skid <= in_beat;
    end
  end

  generate
    if (ADDR_WIDTH >= DATA_WIDTH) begin : g_pcn_trunc
      assign pcn_ext = head.pcn[DATA_WIDTH-1:0];
    end else begin : g_pcn_zext
      assign pcn_ext = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, head.pcn};
    end
  endgenerate

  assign rdw         = head.rd;
  assign pcnw        = head.pcn;
  assign alu_resultw = head.alu_result;
  assign wb_ctrw     = head.wb_ctr;
  assign data_outw   = head.data_out;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Bench for wb_stage_reg: queue-based model checked every negedge, plus directed literal checks.
module tb_wb_stage_reg;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] pcn;
    logic [31:0] alu;
    logic [1:0]  ctr;
    logic [31:0] dat;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic        reg_wem = 1'b0;
  logic [4:0]  rdm = '0;
  logic [31:0] pcnm = '0, alu_resultm = '0, data_out = '0;
  logic [1:0]  wb_ctrm = '0;
  logic        in_ready, out_valid, reg_wew;
  logic [4:0]  rdw;
  logic [31:0] pcnw, alu_resultw, data_outw, wb_dataw;
  logic [1:0]  wb_ctrw, occ;

  int total = 0;
  int bad   = 0;
  beat_t q[$];

  wb_stage_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .reg_wem(reg_wem), .rdm(rdm), .pcnm(pcnm), .alu_resultm(alu_resultm), .wb_ctrm(wb_ctrm),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready), .reg_wew(reg_wew),
    .rdw(rdw), .pcnw(pcnw), .alu_resultw(alu_resultw), .wb_ctrw(wb_ctrw),
    .data_outw(data_outw), .wb_dataw(wb_dataw), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wb_sel(input beat_t b);
    case (b.ctr)
      2'b00:   return b.alu;
      2'b01:   return b.dat;
      2'b10:   return b.pcn;
      default: return 32'h0;
    endcase
  endfunction

  // Model view: the stage is an ordered list of at most two beats.
  always @(negedge clk) begin
    if (rst) begin
      chk("occ", {30'd0, occ}, q.size());
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      if (q.size() > 0) begin
        chk("reg_wew", {31'd0, reg_wew}, {31'd0, q[0].we && q[0].rd != 5'd0});
        chk("rdw", {27'd0, rdw}, {27'd0, q[0].rd});
        chk("alu_resultw", alu_resultw, q[0].alu);
        chk("pcnw", pcnw, q[0].pcn);
        chk("data_outw", data_outw, q[0].dat);
        chk("wb_ctrw", {30'd0, wb_ctrw}, {30'd0, q[0].ctr});
        chk("wb_dataw", wb_dataw, wb_sel(q[0]));
      end else begin
        chk("reg_wew_empty", {31'd0, reg_wew}, 32'd0);
      end
    end
  end

  // Advance one clock; the model consumes the inputs held across the edge.
  task automatic cyc();
    bit acc, ret;
    beat_t b;
    @(posedge clk);
    if (rst) begin
      acc = in_valid && (q.size() < 2);
      ret = out_ready && (q.size() > 0);
      b = '{we: reg_wem, rd: rdm, pcn: pcnm, alu: alu_resultm, ctr: wb_ctrm, dat: data_out};
      if (flush) q.delete();
      else begin
        if (ret) void'(q.pop_front());
        if (acc) q.push_back(b);
      end
    end
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] alu, input logic [1:0] ctr,
                     input logic we, input logic [4:0] rd, input logic [31:0] pcn,
                     input logic [31:0] dat);
    in_valid = v; alu_resultm = alu; wb_ctrm = ctr;
    reg_wem = we; rdm = rd; pcnm = pcn; data_out = dat;
  endtask

  initial begin
    #2;
    chk("rst_occ", {30'd0, occ}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_reg_wew", {31'd0, reg_wew}, 32'd0);
    chk("rst_wb_dataw", wb_dataw, 32'd0);
    cyc(); cyc();
    rst = 1'b1;

    // Streaming: head follows each new beat with no bubble.
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      put(1'b1, i, 2'b00, 1'b1, 5'd3, 32'h100 + i, 32'h200 + i);
      cyc();
      chk("stream_alu", alu_resultw, i);
      chk("stream_occ", {30'd0, occ}, 32'd1);
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
    end

    // WB mux select.
    for (int c = 0; c < 4; c++) begin
      put(1'b1, 32'h11, c[1:0], 1'b1, 5'd7, 32'h33, 32'h22);
      cyc();
      chk("mux", wb_dataw, (c == 0) ? 32'h11 : (c == 1) ? 32'h22 : (c == 2) ? 32'h33 : 32'h0);
    end

    // x0 guard.
    put(1'b1, 32'h5, 2'b00, 1'b1, 5'd0, 32'h0, 32'h0); cyc();
    chk("x0_we1_rd0", {31'd0, reg_wew}, 32'd0);
    put(1'b1, 32'h6, 2'b00, 1'b1, 5'd5, 32'h0, 32'h0); cyc();
    chk("x0_we1_rd5", {31'd0, reg_wew}, 32'd1);
    put(1'b1, 32'h7, 2'b00, 1'b0, 5'd5, 32'h0, 32'h0); cyc();
    chk("x0_we0_rd5", {31'd0, reg_wew}, 32'd0);
    put(1'b0, 32'h0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0); cyc();
    chk("drain_occ", {30'd0, occ}, 32'd0);

    // Back-pressure: A,B fill, C held on input until space opens.
    out_ready = 1'b0;
    put(1'b1, 32'hA, 2'b00, 1'b1, 5'd1, 32'h0, 32'h0); cyc();
    put(1'b1, 32'hB, 2'b00, 1'b1, 5'd2, 32'h0, 32'h0); cyc();
    chk("bp_occ", {30'd0, occ}, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    put(1'b1, 32'hC, 2'b00, 1'b1, 5'd3, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold_head", alu_resultw, 32'hA);
      chk("bp_hold_occ", {30'd0, occ}, 32'd2);
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_head_b", alu_resultw, 32'hB);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("bp_head_c", alu_resultw, 32'hC);
    in_valid = 1'b0; cyc();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush from FULL with a beat on the input.
    out_ready = 1'b0;
    put(1'b1, 32'hD1, 2'b00, 1'b1, 5'd4, 32'h0, 32'h0); cyc();
    put(1'b1, 32'hD2, 2'b00, 1'b1, 5'd4, 32'h0, 32'h0); cyc();
    put(1'b1, 32'hD3, 2'b00, 1'b1, 5'd4, 32'h0, 32'h0);
    flush = 1'b1; cyc(); flush = 1'b0; in_valid = 1'b0;
    chk("flush_occ", {30'd0, occ}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_wew", {31'd0, reg_wew}, 32'd0);
    out_ready = 1'b1; cyc(); cyc();
    chk("flush_stays_empty", {31'd0, out_valid}, 32'd0);

    // Flush from ONE while accepting: incoming beat is discarded too.
    out_ready = 1'b0;
    put(1'b1, 32'hE1, 2'b00, 1'b1, 5'd4, 32'h0, 32'h0); cyc();
    put(1'b1, 32'hE2, 2'b00, 1'b1, 5'd4, 32'h0, 32'h0);
    flush = 1'b1; cyc(); flush = 1'b0; in_valid = 1'b0;
    chk("flush_one_occ", {30'd0, occ}, 32'd0);

    // Asynchronous reset from FULL, asserted between clock edges.
    put(1'b1, 32'hF1, 2'b00, 1'b1, 5'd9, 32'h0, 32'h0); cyc();
    put(1'b1, 32'hF2, 2'b01, 1'b1, 5'd9, 32'h0, 32'h77); cyc();
    in_valid = 1'b0;
    #2 rst = 1'b0; q.delete();
    #1;
    chk("arst_occ", {30'd0, occ}, 32'd0);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_wew", {31'd0, reg_wew}, 32'd0);
    chk("arst_wb_dataw", wb_dataw, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    put(1'b1, 32'h99, 2'b00, 1'b1, 5'd9, 32'h0, 32'h0);
    cyc();
    chk("arst_no_transfer", {30'd0, occ}, 32'd0);
    rst = 1'b1;
    cyc();
    chk("post_rst_occ", {30'd0, occ}, 32'd1);
    chk("post_rst_head", alu_resultw, 32'h99);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      put(1'($urandom_range(0, 3) != 0), $urandom, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
          $urandom, $urandom);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      cyc();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("final_empty", {30'd0, occ}, 32'd0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
